// File: rtl/ie_defs.sv
// Shared IE decode definitions: ALU selector codes, simple-op codes and the decoded-op record
// that travels from the decode pipe to execute.
package ie_defs;

  localparam int IE_OP_W  = 8;
  localparam int IE_SEL_W = 8;

  // ALU selector codes
  localparam logic [IE_SEL_W-1:0] SEL_ZERO       = 8'h00;
  localparam logic [IE_SEL_W-1:0] SEL_MEM_LOAD   = 8'h01;
  localparam logic [IE_SEL_W-1:0] SEL_A_REG      = 8'h02;
  localparam logic [IE_SEL_W-1:0] SEL_X_REG      = 8'h03;
  localparam logic [IE_SEL_W-1:0] SEL_Y_REG      = 8'h04;
  localparam logic [IE_SEL_W-1:0] SEL_STATUS_REG = 8'h05;
  localparam logic [IE_SEL_W-1:0] SEL_STACK_REG  = 8'h06;
  localparam logic [IE_SEL_W-1:0] SEL_IMM        = 8'h07;
  localparam logic [IE_SEL_W-1:0] SEL_ONE        = 8'h08;
  localparam logic [IE_SEL_W-1:0] SEL_MEM_STORE  = 8'h09;

  // Simple-op codes that the classifier recognises
  localparam logic [IE_OP_W-1:0] OP_BRK       = 8'h0C;
  localparam logic [IE_OP_W-1:0] OP_FLAG0_LO  = 8'h0D;
  localparam logic [IE_OP_W-1:0] OP_FLAG0_HI  = 8'h10;
  localparam logic [IE_OP_W-1:0] OP_FLAG1_LO  = 8'h2E;
  localparam logic [IE_OP_W-1:0] OP_FLAG1_HI  = 8'h30;
  localparam logic [IE_OP_W-1:0] OP_STACK_LO  = 8'h24;
  localparam logic [IE_OP_W-1:0] OP_STACK_HI  = 8'h27;
  localparam logic [IE_OP_W-1:0] OP_NOP0      = 8'h22;
  localparam logic [IE_OP_W-1:0] OP_NOP1      = 8'h18;
  localparam logic [IE_OP_W-1:0] OP_JSR       = 8'h1D;
  localparam logic [IE_OP_W-1:0] OP_RTI       = 8'h2A;
  localparam logic [IE_OP_W-1:0] OP_RTS       = 8'h2B;
  localparam logic [IE_OP_W-1:0] OP_A_STATUS  = 8'h25;
  localparam logic [IE_OP_W-1:0] OP_A_STACK   = 8'h36;
  localparam logic [IE_OP_W-1:0] OP_BCC       = 8'h03;
  localparam logic [IE_OP_W-1:0] OP_BCS       = 8'h04;
  localparam logic [IE_OP_W-1:0] OP_BEQ       = 8'h05;
  localparam logic [IE_OP_W-1:0] OP_BMI       = 8'h07;
  localparam logic [IE_OP_W-1:0] OP_BNE       = 8'h08;
  localparam logic [IE_OP_W-1:0] OP_BPL       = 8'h09;
  localparam logic [IE_OP_W-1:0] OP_BVC       = 8'h0A;
  localparam logic [IE_OP_W-1:0] OP_BVS       = 8'h0B;
  localparam logic [IE_OP_W-1:0] OP_JMP       = 8'h1C;

  localparam logic [7:0] STATUS_EDIT = 8'b1000_0010;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic [IE_OP_W-1:0]  op;
    logic                is_break;
    logic                is_flag;
    logic                is_stack;
    logic                is_nop;
    logic                is_jsr;
    logic                is_rti;
    logic                is_rts;
    logic                is_branch;
    logic                is_load;
    logic                is_store;
    logic [IE_SEL_W-1:0] alu_a_sel;
    logic [IE_SEL_W-1:0] alu_b_sel;
    logic [IE_SEL_W-1:0] alu_out_sel;
    logic [7:0]          status_edit;
  } decoded_op_t;

endpackage

// File: rtl/ie_op_classify.sv
// Combinational classifier: simple op plus load/store/reg flags -> decoded_op_t and a
// control-flow indication used by the pipe's hold FSM.
module ie_op_classify
  import ie_defs::*;
#(
  parameter int OP_W  = 8,
  parameter int SEL_W = 8
) (
  input  logic [OP_W-1:0] simple_op_i,
  input  logic            mem_load_flag_i,
  input  logic [2:0]      store_flag_i,
  input  logic [1:0]      reg_load_flag_i,
  input  logic            immediate_flag_i,
  output decoded_op_t     dec_o,
  output logic            is_ctrl_o
);

  logic [IE_OP_W-1:0] op;
  logic [SEL_W-1:0]   a_sel;
  logic [SEL_W-1:0]   b_sel;
  logic [SEL_W-1:0]   out_sel;

  assign op = IE_OP_W'(simple_op_i);

  always_comb begin
    a_sel = SEL_ZERO;
    if (op == OP_A_STATUS) begin
      a_sel = SEL_STATUS_REG;
    end else if (op == OP_A_STACK) begin
      a_sel = SEL_STACK_REG;
    end else begin
      case (reg_load_flag_i)
        2'b00:   a_sel = SEL_MEM_LOAD;
        2'b01:   a_sel = SEL_A_REG;
        2'b10:   a_sel = SEL_X_REG;
        default: a_sel = SEL_Y_REG;
      endcase
    end
  end

  always_comb begin
    case (store_flag_i)
      3'b001:  out_sel = SEL_MEM_STORE;
      3'b010:  out_sel = SEL_A_REG;
      3'b011:  out_sel = SEL_X_REG;
      3'b100:  out_sel = SEL_Y_REG;
      3'b110:  out_sel = SEL_STACK_REG;
      3'b111:  out_sel = SEL_STATUS_REG;
      default: out_sel = SEL_ZERO;
    endcase
  end

  // Read-modify-write of a non-accumulator target needs a constant one on B
  always_comb begin
    if (immediate_flag_i) begin
      b_sel = SEL_IMM;
    end else if (((a_sel == out_sel) ||
                  ((a_sel == SEL_MEM_LOAD) && (out_sel == SEL_MEM_STORE))) &&
                 (a_sel != SEL_A_REG)) begin
      b_sel = SEL_ONE;
    end else if (mem_load_flag_i && (a_sel == SEL_A_REG)) begin
      b_sel = SEL_MEM_LOAD;
    end else begin
      b_sel = SEL_ZERO;
    end
  end

  always_comb begin
    dec_o             = '0;
    dec_o.op          = op;
    dec_o.is_break    = (op == OP_BRK);
    dec_o.is_flag     = ((op >= OP_FLAG0_LO) && (op <= OP_FLAG0_HI)) ||
                        ((op >= OP_FLAG1_LO) && (op <= OP_FLAG1_HI));
    dec_o.is_stack    = (op >= OP_STACK_LO) && (op <= OP_STACK_HI);
    dec_o.is_nop      = (op == OP_NOP0) || (op == OP_NOP1);
    dec_o.is_jsr      = (op == OP_JSR);
    dec_o.is_rti      = (op == OP_RTI);
    dec_o.is_rts      = (op == OP_RTS);
    dec_o.is_branch   = (op == OP_BCC) || (op == OP_BCS) || (op == OP_BEQ) ||
                        (op == OP_BMI) || (op == OP_BNE) || (op == OP_BPL) ||
                        (op == OP_BVC) || (op == OP_BVS) || (op == OP_JMP);
    dec_o.is_load     = mem_load_flag_i;
    dec_o.is_store    = (store_flag_i == 3'b001);
    dec_o.alu_a_sel   = IE_SEL_W'(a_sel);
    dec_o.alu_b_sel   = IE_SEL_W'(b_sel);
    dec_o.alu_out_sel = IE_SEL_W'(out_sel);
    dec_o.status_edit = STATUS_EDIT;
  end

  assign is_ctrl_o = dec_o.is_branch | dec_o.is_jsr | dec_o.is_rts |
                     dec_o.is_rti | dec_o.is_break;

endmodule

// File: rtl/ie_op_decode_pipe.sv
// Buffered IE simple-op decoder: classify at enqueue, queue in a DEPTH-entry FIFO, and stall
// intake after a control-flow op until execute resolves or flushes it.
module ie_op_decode_pipe
  import ie_defs::*;
#(
  parameter int OP_W  = 8,
  parameter int SEL_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            simple_op,
  input  logic                       mem_load_flag,
  input  logic [2:0]                 store_flag,
  input  logic [1:0]                 reg_load_flag,
  input  logic                       immediate_flag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output decoded_op_t                out_op,
  input  logic                       resolve,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       hold
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  decoded_op_t fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_state_e      state_q, state_d;

  decoded_op_t dec;
  logic        dec_is_ctrl;
  logic        push;
  logic        pop;

  ie_op_classify #(
    .OP_W  (OP_W),
    .SEL_W (SEL_W)
  ) u_classify (
    .simple_op_i      (simple_op),
    .mem_load_flag_i  (mem_load_flag),
    .store_flag_i     (store_flag),
    .reg_load_flag_i  (reg_load_flag),
    .immediate_flag_i (immediate_flag),
    .dec_o            (dec),
    .is_ctrl_o        (dec_is_ctrl)
  );

  assign in_ready  = (state_q == RUN) && (count_q < CNT_W'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_op    = fifo_q[rd_ptr_q];
  assign count     = count_q;
  assign hold      = (state_q == HOLD);

  // Flush wins over everything, including a same-cycle pop
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    state_d = state_q;
    case (state_q)
      RUN:     if (push && dec_is_ctrl) state_d = HOLD;
      HOLD:    if (resolve || flush) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fifo_q[gi] <= '0;
      end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
        fifo_q[gi] <= dec;
      end
    end
  end

endmodule

// File: tb/tb_ie_op_decode_pipe.sv
// Scoreboard bench for ie_op_decode_pipe: accepted ops are modelled and queued, and every
// consumed head is compared against the queue front.
module tb_ie_op_decode_pipe;
  import ie_defs::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  simple_op;
  logic        mem_load_flag;
  logic [2:0]  store_flag;
  logic [1:0]  reg_load_flag;
  logic        immediate_flag;
  logic        out_valid;
  logic        out_ready;
  decoded_op_t out_op;
  logic        resolve;
  logic        flush;
  logic [2:0]  count;
  logic        hold;

  int n_cmp;
  int n_err;
  decoded_op_t sb[$];

  ie_op_decode_pipe #(.OP_W(8), .SEL_W(8), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .simple_op      (simple_op),
    .mem_load_flag  (mem_load_flag),
    .store_flag     (store_flag),
    .reg_load_flag  (reg_load_flag),
    .immediate_flag (immediate_flag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_op         (out_op),
    .resolve        (resolve),
    .flush          (flush),
    .count          (count),
    .hold           (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic decoded_op_t model(input logic [7:0] op, input logic ml,
                                        input logic [2:0] sf, input logic [1:0] rl,
                                        input logic imm);
    decoded_op_t d;
    logic [7:0] a_tab [4];
    logic [7:0] o_tab [8];
    a_tab = '{8'h01, 8'h02, 8'h03, 8'h04};
    o_tab = '{8'h00, 8'h09, 8'h02, 8'h03, 8'h04, 8'h00, 8'h06, 8'h05};
    d = '0;
    d.op        = op;
    d.is_break  = (op == 8'h0C);
    d.is_flag   = op inside {[8'h0D:8'h10], [8'h2E:8'h30]};
    d.is_stack  = op inside {[8'h24:8'h27]};
    d.is_nop    = op inside {8'h22, 8'h18};
    d.is_jsr    = (op == 8'h1D);
    d.is_rti    = (op == 8'h2A);
    d.is_rts    = (op == 8'h2B);
    d.is_branch = op inside {8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h1C};
    d.is_load   = ml;
    d.is_store  = (sf == 3'b001);
    d.alu_a_sel = (op == 8'h25) ? 8'h05 : (op == 8'h36) ? 8'h06 : a_tab[rl];
    d.alu_out_sel = o_tab[sf];
    if (imm)
      d.alu_b_sel = 8'h07;
    else if (d.alu_a_sel != 8'h02 &&
             (d.alu_a_sel == d.alu_out_sel || (d.alu_a_sel == 8'h01 && d.alu_out_sel == 8'h09)))
      d.alu_b_sel = 8'h08;
    else if (ml && d.alu_a_sel == 8'h02)
      d.alu_b_sel = 8'h01;
    else
      d.alu_b_sel = 8'h00;
    d.status_edit = 8'h82;
    return d;
  endfunction

  // Scoreboard: compare consumed heads, then record newly accepted ops
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
        else chk("out_op", 64'(out_op), 64'(sb.pop_front()));
      end
      if (in_valid && in_ready)
        sb.push_back(model(simple_op, mem_load_flag, store_flag, reg_load_flag, immediate_flag));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] op, input logic ml,
                        input logic [2:0] sf, input logic [1:0] rl, input logic imm);
    in_valid       = v;
    simple_op      = op;
    mem_load_flag  = ml;
    store_flag     = sf;
    reg_load_flag  = rl;
    immediate_flag = imm;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && count != 0; n++) tick();
    chk(tag, 64'(count), 64'(0));
    out_ready = 1'b0;
  endtask

  task automatic b_case(input string tag, input logic ml, input logic [2:0] sf,
                        input logic [1:0] rl, input logic imm, input logic [7:0] exp_b);
    set_in(1'b1, 8'h40, ml, sf, rl, imm);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 3'b000, 2'b00, 1'b0);
    chk(tag, 64'(out_op.alu_b_sel), 64'(exp_b));
    drain({tag, "_drain"});
  endtask

  initial begin
    logic [7:0] ops [8];
    ops = '{8'h25, 8'h36, 8'h0E, 8'h24, 8'h22, 8'h2F, 8'h40, 8'h11};
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    resolve = 1'b0;
    flush = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 3'b000, 2'b00, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_op", 64'(out_op), 64'(0));
    chk("rst_hold", 64'(hold), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    tick();

    // 1: single flag op, no bypass, then drain
    set_in(1'b1, 8'h0D, 1'b0, 3'b000, 2'b00, 1'b0);
    chk("t1_out_valid_pre", 64'(out_valid), 64'(0));
    tick();
    set_in(1'b0, 8'h00, 1'b0, 3'b000, 2'b00, 1'b0);
    chk("t1_out_valid", 64'(out_valid), 64'(1));
    chk("t1_flag", 64'(out_op.is_flag), 64'(1));
    chk("t1_out_sel", 64'(out_op.alu_out_sel), 64'(SEL_ZERO));
    out_ready = 1'b1;
    tick();
    chk("t1_count", 64'(count), 64'(0));
    out_ready = 1'b0;

    // 2: fill, full push+pop refused, then streaming across pointer wrap
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, ops[i], i[0], 3'(i + 1), 2'(i), i[1]);
      tick();
    end
    set_in(1'b1, 8'h44, 1'b0, 3'b010, 2'b01, 1'b0);
    out_ready = 1'b1;
    chk("t2_count_full", 64'(count), 64'(4));
    chk("t2_in_ready_full", 64'(in_ready), 64'(0));
    tick();
    chk("t2_count_after", 64'(count), 64'(3));
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, ops[i], i[1], 3'(7 - i), 2'(i + 1), i[2]);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 3'b000, 2'b00, 1'b0);
    drain("t2_drain");

    // 3: branch holds intake until resolve
    set_in(1'b1, 8'h05, 1'b0, 3'b000, 2'b00, 1'b0);
    tick();
    set_in(1'b1, 8'h22, 1'b0, 3'b000, 2'b01, 1'b0);
    chk("t3_hold", 64'(hold), 64'(1));
    chk("t3_in_ready", 64'(in_ready), 64'(0));
    tick();
    chk("t3_not_accepted", 64'(count), 64'(1));
    resolve = 1'b1;
    tick();
    resolve = 1'b0;
    chk("t3_hold_clear", 64'(hold), 64'(0));
    chk("t3_in_ready_back", 64'(in_ready), 64'(1));
    tick();
    set_in(1'b0, 8'h00, 1'b0, 3'b000, 2'b00, 1'b0);
    chk("t3_accepted", 64'(count), 64'(2));
    drain("t3_drain");

    // 4: B selector priorities
    b_case("t4_b_one", 1'b0, 3'b011, 2'b10, 1'b0, SEL_ONE);
    b_case("t4_b_mem", 1'b1, 3'b010, 2'b01, 1'b0, SEL_MEM_LOAD);
    b_case("t4_b_imm", 1'b1, 3'b010, 2'b01, 1'b1, SEL_IMM);
    b_case("t4_b_one_mem", 1'b1, 3'b001, 2'b00, 1'b0, SEL_ONE);
    b_case("t4_b_zero", 1'b0, 3'b100, 2'b01, 1'b0, SEL_ZERO);

    // 5: flush in HOLD with a pending push and pop
    set_in(1'b1, 8'h40, 1'b0, 3'b010, 2'b01, 1'b0);
    tick();
    set_in(1'b1, 8'h26, 1'b1, 3'b011, 2'b10, 1'b0);
    tick();
    set_in(1'b1, 8'h1C, 1'b0, 3'b000, 2'b00, 1'b0);
    tick();
    set_in(1'b1, 8'h50, 1'b0, 3'b010, 2'b01, 1'b0);
    chk("t5_hold", 64'(hold), 64'(1));
    chk("t5_count", 64'(count), 64'(3));
    flush = 1'b1;
    out_ready = 1'b1;
    chk("t5_in_ready_flush", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 3'b000, 2'b00, 1'b0);
    chk("t5_count_zero", 64'(count), 64'(0));
    chk("t5_hold_zero", 64'(hold), 64'(0));
    chk("t5_out_valid", 64'(out_valid), 64'(0));

    // 6: asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, ops[i + 4], 1'b0, 3'b011, 2'b11, 1'b0);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 3'b000, 2'b00, 1'b0);
    out_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    chk("t6_count", 64'(count), 64'(0));
    chk("t6_hold", 64'(hold), 64'(0));
    chk("t6_out_op", 64'(out_op), 64'(0));
    chk("t6_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
